irq_ctrl: RTL and testbench

//  Interrupt source side of the core's trap path: drives e_inter into csr_reg. Merges a 64-bit machine

---
 rtl/irq_pkg.sv | 16 +
 rtl/irq_sync_edge.sv | 29 ++
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets and claim ID encoding.
package irq_pkg;

  localparam int ID_W_DEF = 5;
  localparam int ID_NONE  = 0;

  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_PENDING     = 5'h10;
  localparam logic [4:0] OFF_ENABLE      = 5'h14;
  localparam logic [4:0] OFF_CLAIM       = 5'h18;
  localparam logic [4:0] OFF_CTRL        = 5'h1C;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] pulse
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Machine timer plus external-line interrupt merger with claim/complete over a register port.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int PRESCALE = 1,
  parameter int ID_W     = ID_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             bus_en,
  input  logic             bus_we,
  input  logic [4:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             e_inter,
  output logic             timer_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic [63:0]      mtime_inc;
  logic [PW-1:0]    pre_cnt;
  logic             timer_en;
  logic             tick;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] edge_pulse;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] claim_oh;
  logic [ID_W-1:0]  claim_id;
  logic [ID_W-1:0]  svc_id;
  logic             svc_any;
  logic [4:0]       word_addr;
  logic             rd;
  logic             wr;
  logic             claim_go;
  logic             complete_go;
  logic [31:0]      rd_val;
  logic             unused_addr_bits;

  irq_sync_edge #(.W(N_SRC)) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (irq_src),
    .pulse (edge_pulse)
  );

  assign unused_addr_bits = ^bus_addr[1:0];
  assign word_addr = {bus_addr[4:2], 2'b00};
  assign rd        = bus_en & ~bus_we;
  assign wr        = bus_en & bus_we;
  assign tick      = timer_en && (pre_cnt == PW'(PRESCALE - 1));
  assign mtime_inc = mtime + 64'd1;
  assign svc_any   = (svc_id != ID_W'(ID_NONE));
  assign eligible  = pending & enable;

  // Descending scan so the lowest eligible index is the one left standing.
  always_comb begin
    claim_id = ID_W'(ID_NONE);
    claim_oh = '0;
    if (!svc_any) begin
      for (int k = N_SRC - 1; k >= 0; k--) begin
        if (eligible[k]) begin
          claim_id = ID_W'(k + 1);
          claim_oh = N_SRC'(1) << k;
        end
      end
    end
  end

  assign claim_go    = rd && (word_addr == OFF_CLAIM) && (claim_id != ID_W'(ID_NONE));
  assign complete_go = wr && (word_addr == OFF_CLAIM) && svc_any &&
                       (bus_wdata[ID_W-1:0] == svc_id);

  always_comb begin
    rd_val = '0;
    case (word_addr)
      OFF_MTIME_LO:    rd_val = mtime[31:0];
      OFF_MTIME_HI:    rd_val = mtime[63:32];
      OFF_MTIMECMP_LO: rd_val = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_val = mtimecmp[63:32];
      OFF_PENDING:     rd_val = 32'(pending);
      OFF_ENABLE:      rd_val = 32'(enable);
      OFF_CLAIM:       rd_val = 32'(claim_id);
      OFF_CTRL:        rd_val = {31'd0, timer_en};
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      pre_cnt   <= '0;
      timer_en  <= 1'b0;
      pending   <= '0;
      enable    <= '0;
      svc_id    <= ID_W'(ID_NONE);
      timer_irq <= 1'b0;
      e_inter   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      if (timer_en) pre_cnt <= tick ? '0 : pre_cnt + PW'(1);

      // A bus write owns its half for the cycle; no carry crosses into the written half.
      if (wr && word_addr == OFF_MTIME_LO) begin
        mtime[31:0] <= bus_wdata;
      end else if (wr && word_addr == OFF_MTIME_HI) begin
        mtime[63:32] <= bus_wdata;
        if (tick) mtime[31:0] <= mtime_inc[31:0];
      end else if (tick) begin
        mtime <= mtime_inc;
      end

      if (wr && word_addr == OFF_MTIMECMP_LO) mtimecmp[31:0]  <= bus_wdata;
      if (wr && word_addr == OFF_MTIMECMP_HI) mtimecmp[63:32] <= bus_wdata;
      if (wr && word_addr == OFF_ENABLE)      enable          <= bus_wdata[N_SRC-1:0];
      if (wr && word_addr == OFF_CTRL)        timer_en        <= bus_wdata[0];

      pending <= (pending & ~(claim_go ? claim_oh : '0)) | edge_pulse;

      if (claim_go)         svc_id <= claim_id;
      else if (complete_go) svc_id <= ID_W'(ID_NONE);

      timer_irq <= (mtime >= mtimecmp);
      e_inter   <= (timer_irq & timer_en) | ((|eligible) & ~svc_any);

      if (rd) bus_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register reset values, timer compare, claim/complete, mtime carry, reset.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        bus_en;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        e_inter;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.N_SRC(8), .PRESCALE(1), .ID_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .bus_en    (bus_en),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .e_inter   (e_inter),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered on a negedge and leave on the next negedge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_en = 1'b0;
    d = bus_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_src(input logic [7:0] m);
    irq_src = m;
    idle(3);
    irq_src = '0;
    idle(5);
  endtask

  logic [31:0] v;
  int          waited;

  initial begin
    rst_n = 1'b0; irq_src = '0; bus_en = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset values
    chk("rst_e_inter", e_inter, 0);
    chk("rst_timer_irq", timer_irq, 0);
    rd(5'h00, v); chk("rst_mtime_lo", v, 0);
    rd(5'h04, v); chk("rst_mtime_hi", v, 0);
    rd(5'h08, v); chk("rst_cmp_lo", v, 32'hFFFF_FFFF);
    rd(5'h0C, v); chk("rst_cmp_hi", v, 32'hFFFF_FFFF);
    rd(5'h10, v); chk("rst_pending", v, 0);
    rd(5'h14, v); chk("rst_enable", v, 0);
    rd(5'h18, v); chk("rst_claim", v, 0);
    rd(5'h1C, v); chk("rst_ctrl", v, 0);

    // Timer compare
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd10);
    wr(5'h1C, 32'd1);
    chk("tmr_e_inter_early", e_inter, 0);
    waited = 0;
    while (!e_inter && waited < 50) begin
      idle(1);
      waited++;
    end
    chk("tmr_e_inter_rise", e_inter, 1);
    chk("tmr_irq_high", timer_irq, 1);
    rd(5'h00, v);
    chk("tmr_mtime_range", 64'((v >= 32'd10) && (v <= 32'd16)), 1);
    wr(5'h08, 32'd100);
    idle(3);
    chk("tmr_irq_drop", timer_irq, 0);
    chk("tmr_e_inter_drop", e_inter, 0);
    wr(5'h1C, 32'd0);

    // External sources 2 and 3 together
    wr(5'h14, 32'h0C);
    pulse_src(8'h0C);
    chk("ext_e_inter", e_inter, 1);
    rd(5'h10, v); chk("ext_pending", v, 32'h0C);
    rd(5'h18, v); chk("ext_claim_3", v, 3);
    rd(5'h18, v); chk("ext_claim_busy", v, 0);
    idle(1);
    chk("ext_e_inter_svc", e_inter, 0);
    wr(5'h18, 32'd5);
    rd(5'h18, v); chk("ext_bad_complete", v, 0);
    wr(5'h18, 32'd3);
    rd(5'h18, v); chk("ext_claim_4", v, 4);
    wr(5'h18, 32'd4);
    rd(5'h10, v); chk("ext_pending_clr", v, 0);
    idle(1);
    chk("ext_e_inter_idle", e_inter, 0);

    // Disabled source keeps pending but stays silent
    pulse_src(8'h01);
    chk("dis_e_inter", e_inter, 0);
    rd(5'h10, v); chk("dis_pending", v, 32'h01);
    rd(5'h18, v); chk("dis_claim", v, 0);
    wr(5'h14, 32'h01);
    idle(2);
    chk("dis_enable_e_inter", e_inter, 1);
    rd(5'h18, v); chk("dis_claim_1", v, 1);
    wr(5'h18, 32'd1);

    // mtime carry across halves, one tick
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h04, 32'd0);
    wr(5'h1C, 32'd1);
    wr(5'h1C, 32'd0);
    rd(5'h04, v); chk("carry_hi", v, 1);
    rd(5'h00, v); chk("carry_lo", v, 0);

    // Write on a tick cycle wins over the increment
    wr(5'h1C, 32'd1);
    wr(5'h00, 32'd5);
    rd(5'h00, v); chk("tick_wr_lo", v, 5);
    rd(5'h04, v); chk("tick_wr_hi", v, 1);
    wr(5'h1C, 32'd0);

    // Reset while in service with e_inter high
    wr(5'h14, 32'h0C);
    pulse_src(8'h0C);
    rd(5'h18, v); chk("rstsvc_claim", v, 3);
    wr(5'h08, 32'd0);
    wr(5'h0C, 32'd0);
    wr(5'h1C, 32'd1);
    idle(2);
    chk("rstsvc_e_inter_hi", e_inter, 1);
    rst_n = 1'b0;
    idle(1);
    chk("rstsvc_e_inter_lo", e_inter, 0);
    rst_n = 1'b1;
    rd(5'h10, v); chk("rstsvc_pending", v, 0);
    rd(5'h18, v); chk("rstsvc_claim0", v, 0);
    rd(5'h08, v); chk("rstsvc_cmp_lo", v, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
